serial_bus_master_port: RTL and testbench
=========================================

Name: serial_bus_master_port

Overview:
Initiator end of the serial slave bus. Accepts a parallel transaction request (slave id, R/W, write word) from a local master. It then serialises the control frame on `control`, shifts write data on `wD` qualified by `valid`, or collects read data from `rD` qualified by `ready`. Sits between a bus master core and the interconnect, facing slaves such as the UART slave. A response timeout issues an ABORT frame and reports an error.

Parameters:
SLAVES, 3, number of addressable slaves
DATA_WIDTH, 32, data word width in bits
S_ID_WIDTH, $clog2(SLAVES+1), slave id field width
TIMEOUT, 1024, cycles without slave response before abort (must be ≥2)

Ports:
clk  input  1  system clock
rstN  input  1  asynchronous active-low reset
reqStart  input  1  request strobe; accepted only when busy=0
reqSlaveId  input  S_ID_WIDTH  target slave id
reqRW  input  1  1=write, 0=read
reqWrData  input  DATA_WIDTH  write word
rdData  output  DATA_WIDTH  read word; valid when done=1 and error=0
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse with done on timeout
busy  output  1  high from accept until the cycle after done
control  output  1  serial control line, idles low
wD  output  1  serial write data, MSB first
valid  output  1  write-data qualifier / read acknowledge
rD  input  1  serial read data, MSB first
ready  input  1  slave ready / read-data qualifier

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rstN. All state updates on posedge clk.
- Reset values: all outputs 0 (control, wD, valid, done, error, busy, rdData). State is IDLE, counters 0.
- Reset mid-transaction abandons the transaction immediately. No abort frame is sent.
- All bus outputs are registered.
- Control frame width CON = 3+S_ID_WIDTH+1, sent MSB first: START code 3'b111, then slave id MSB first, then R/W bit (1=write).
- ABORT frame is 3'b100.
- States and transitions:
  - IDLE: on reqStart, latch id/RW/data, set busy=1, go to CTRL. reqStart while busy is ignored.
  - CTRL: drive one frame bit per cycle for CON cycles. The first bit appears the cycle after accept. Then control=0 and go to WAIT_RDY (write) or READ (read).
  - WAIT_RDY: wait for ready=1, then go to WRITE.
  - WRITE: valid=1 for exactly DATA_WIDTH consecutive cycles, with wD = data[DATA_WIDTH-1-k] in cycle k. `ready` is ignored once started. Then valid=0 and go to FIN.
  - READ: each cycle with ready=1, shift rD into the LSB of the capture register (first sampled bit ends as MSB). After DATA_WIDTH samples, go to ACK.
  - ACK: valid=1 for one cycle. Load rdData from the capture register. Go to FIN.
  - ABRT: drive 1,0,0 on control over 3 cycles. Set the error flag. Go to FIN.
  - FIN: done=1 (and error=1 if flagged) for one cycle. Go to IDLE. busy drops the following cycle.
- Timeout counter:
  - Counts cycles in WAIT_RDY, and cycles in READ with ready=0.
  - Cleared on every sampled read bit and on state entry.
  - Reaching TIMEOUT-1 goes to ABRT; any partial read is discarded.
  - If ready=1 arrives in the same cycle the count reaches TIMEOUT-1, ready wins.
- rdData holds its last value until the next successful read; it is unchanged on write or error.
- Latency (no stalls): write = 1+CON+1(wait min)+DATA_WIDTH+1 cycles to done. Read = 1+CON+DATA_WIDTH+1+1.
- Counters are sized $clog2(max+1). No wrap-around is permitted within a transaction.

Decomposition:
- Package serial_bus_pkg holds:
  - control_ enum: ABORT=3'b100, CONTINUE=3'b101, HOLD=3'b110, START=3'b111
  - CON width function
  - master state enum
  - the package is shared with the slave blocks
- One sub-module, bus_timeout_counter: enable, clear, TIMEOUT param, expired output.

Test Plan:
- Reset asserted mid-WRITE → all outputs 0 within the same cycle (async); next request completes normally.
- Write id=1, data=32'hA5A5_0F0F, ready high (S_ID_WIDTH=2, CON=6):
  - control 1,1,1,0,1,1 over 6 cycles;
  - valid high 32 cycles with wD sequence matching hA5A50F0F MSB first;
  - done pulse; error=0.
- Read id=2, slave streams 32'hDEAD_BEEF with ready toggling 1,0,1,0…:
  - control 1,1,1,1,0,0;
  - only ready=1 cycles sampled;
  - valid pulses once;
  - rdData=32'hDEADBEEF with done.
- Timeout, TIMEOUT=16, read id=3, ready held 0:
  - after 15 waiting cycles control emits 1,0,0;
  - done=1 and error=1 pulse together;
  - rdData unchanged.
- reqStart held high through a whole write → exactly one transaction; a second starts only after busy falls.
- Read with ready rising on the timeout-expiry cycle → bit sampled, no abort, read completes.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial slave bus: control-line codes, frame width
// and the master FSM state encoding. Also used by the slave-side blocks.
package serial_bus_pkg;

   typedef enum logic [2:0] {
      ABORT    = 3'b100,
      CONTINUE = 3'b101,
      HOLD     = 3'b110,
      START    = 3'b111
   } control_e;

   localparam int CODE_W = 3;

   // Control frame: 3-bit code, slave id, then the R/W bit.
   function automatic int con_width(input int s_id_width);
      return CODE_W + s_id_width + 1;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CTRL     = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_WRITE    = 3'd3,
      ST_READ     = 3'd4,
      ST_ACK      = 3'd5,
      ST_ABRT     = 3'd6,
      ST_FIN      = 3'd7
   } master_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Response watchdog: counts enabled cycles and flags the cycle in which the
// count reaches TIMEOUT-1. Clear has priority; the count never wraps.
module bus_timeout_counter #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires on the cycle whose increment would land on TIMEOUT-1.
   assign expired_o = en_i && !clear_i && (cnt_q == CNT_PRE);

endmodule

// File: rtl/serial_bus_master_port.sv
// Initiator end of the serial slave bus: serialises a control frame, then
// shifts a write word out on wD or collects a read word from rD.
module serial_bus_master_port
   import serial_bus_pkg::*;
#(
   parameter int SLAVES     = 3,
   parameter int DATA_WIDTH = 32,
   parameter int S_ID_WIDTH = $clog2(SLAVES + 1),
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  reqStart,
   input  logic [S_ID_WIDTH-1:0] reqSlaveId,
   input  logic                  reqRW,
   input  logic [DATA_WIDTH-1:0] reqWrData,
   output logic [DATA_WIDTH-1:0] rdData,
   output logic                  done,
   output logic                  error,
   output logic                  busy,
   output logic                  control,
   output logic                  wD,
   output logic                  valid,
   input  logic                  rD,
   input  logic                  ready
);

   localparam int CON      = con_width(S_ID_WIDTH);
   localparam int BCNT_MAX = (DATA_WIDTH > CON) ? DATA_WIDTH : CON;
   localparam int BCNT_W   = $clog2(BCNT_MAX + 1);

   localparam logic [BCNT_W-1:0]     CON_LAST   = BCNT_W'(CON - 1);
   localparam logic [BCNT_W-1:0]     DATA_LAST  = BCNT_W'(DATA_WIDTH - 1);
   localparam logic [BCNT_W-1:0]     ABRT_LAST  = BCNT_W'(CODE_W - 1);
   localparam logic [CON-1:0]        FRAME_MSB  = {1'b1, {(CON-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] DATA_MSB   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CODE_W-1:0]     CODE_MSB   = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [CODE_W-1:0]     ABORT_BITS = ABORT;
   localparam logic [CODE_W-1:0]     START_BITS = START;

   master_state_e         state_q, state_d;
   logic [BCNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [S_ID_WIDTH-1:0] id_q, id_d;
   logic                  rw_q, rw_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] cap_q, cap_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  control_q, control_d;
   logic                  wd_q, wd_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  busy_q, busy_d;

   logic [CON-1:0]        frame;
   logic                  to_en, to_clear, to_expired;

   assign to_en    = (state_q == ST_WAIT_RDY) || ((state_q == ST_READ) && !ready);
   assign to_clear = !((state_q == ST_WAIT_RDY) || (state_q == ST_READ)) ||
                     ((state_q == ST_READ) && ready);

   bus_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (clk),
      .rst_ni    (rstN),
      .en_i      (to_en),
      .clear_i   (to_clear),
      .expired_o (to_expired)
   );

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      id_d      = id_q;
      rw_d      = rw_q;
      wdata_d   = wdata_q;
      cap_d     = cap_q;
      rd_data_d = rd_data_q;

      case (state_q)
         ST_IDLE: begin
            if (reqStart) begin
               id_d     = reqSlaveId;
               rw_d     = reqRW;
               wdata_d  = reqWrData;
               cap_d    = '0;
               bitcnt_d = '0;
               state_d  = ST_CTRL;
            end
         end
         ST_CTRL: begin
            if (bitcnt_q == CON_LAST) begin
               bitcnt_d = '0;
               state_d  = rw_q ? ST_WAIT_RDY : ST_READ;
            end else begin
               bitcnt_d = bitcnt_q + BCNT_W'(1);
            end
         end
         ST_WAIT_RDY: begin
            if (ready) begin
               state_d = ST_WRITE;
            end else if (to_expired) begin
               state_d = ST_ABRT;
            end
         end
         ST_WRITE: begin
            if (bitcnt_q == DATA_LAST) begin
               bitcnt_d = '0;
               state_d  = ST_FIN;
            end else begin
               bitcnt_d = bitcnt_q + BCNT_W'(1);
            end
         end
         ST_READ: begin
            // A sampled bit beats an expiring timeout in the same cycle.
            if (ready) begin
               cap_d = {cap_q[DATA_WIDTH-2:0], rD};
               if (bitcnt_q == DATA_LAST) begin
                  bitcnt_d = '0;
                  state_d  = ST_ACK;
               end else begin
                  bitcnt_d = bitcnt_q + BCNT_W'(1);
               end
            end else if (to_expired) begin
               bitcnt_d = '0;
               state_d  = ST_ABRT;
            end
         end
         ST_ACK: begin
            rd_data_d = cap_q;
            state_d   = ST_FIN;
         end
         ST_ABRT: begin
            if (bitcnt_q == ABRT_LAST) begin
               bitcnt_d = '0;
               state_d  = ST_FIN;
            end else begin
               bitcnt_d = bitcnt_q + BCNT_W'(1);
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            bitcnt_d = '0;
            state_d  = ST_IDLE;
         end
      endcase

      // Bus outputs are registered from the next state so they line up with state_q.
      frame     = {START_BITS, id_d, rw_d};
      control_d = 1'b0;
      wd_d      = 1'b0;
      valid_d   = 1'b0;
      done_d    = (state_d == ST_FIN);
      error_d   = (state_d == ST_FIN) && (state_q == ST_ABRT);
      busy_d    = (state_d != ST_IDLE);

      case (state_d)
         ST_CTRL:  control_d = |(frame & (FRAME_MSB >> bitcnt_d));
         ST_ABRT:  control_d = |(ABORT_BITS & (CODE_MSB >> bitcnt_d));
         ST_WRITE: begin
            valid_d = 1'b1;
            wd_d    = |(wdata_d & (DATA_MSB >> bitcnt_d));
         end
         ST_ACK:   valid_d = 1'b1;
         default:  valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= ST_IDLE;
         bitcnt_q  <= '0;
         rd_data_q <= '0;
         control_q <= 1'b0;
         wd_q      <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         rd_data_q <= rd_data_d;
         control_q <= control_d;
         wd_q      <= wd_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
      end
   end

   // Request and shift registers carry data only; they are always loaded before use.
   always_ff @(posedge clk) begin
      id_q    <= id_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
   end

   assign rdData  = rd_data_q;
   assign done    = done_q;
   assign error   = error_q;
   assign busy    = busy_q;
   assign control = control_q;
   assign wD      = wd_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_serial_bus_master_port.sv
// Directed bench for serial_bus_master_port (DATA_WIDTH=32, S_ID_WIDTH=2, CON=6, TIMEOUT=16).
module tb_serial_bus_master_port;

   localparam int DW  = 32;
   localparam int IDW = 2;
   localparam int CON = 6;
   localparam int TO  = 16;

   logic           clk = 1'b0;
   logic           rstN;
   logic           reqStart;
   logic [IDW-1:0] reqSlaveId;
   logic           reqRW;
   logic [DW-1:0]  reqWrData;
   logic [DW-1:0]  rdData;
   logic           done, error, busy, control, wD, valid;
   logic           rD, ready;

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_rd;
   logic [DW-1:0] dones;

   always #5 clk = ~clk;

   serial_bus_master_port #(
      .SLAVES     (3),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rstN       (rstN),
      .reqStart   (reqStart),
      .reqSlaveId (reqSlaveId),
      .reqRW      (reqRW),
      .reqWrData  (reqWrData),
      .rdData     (rdData),
      .done       (done),
      .error      (error),
      .busy       (busy),
      .control    (control),
      .wD         (wD),
      .valid      (valid),
      .rD         (rD),
      .ready      (ready)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl_frame(input string tag, input logic [CON-1:0] frame);
      logic [CON-1:0] f;
      f = frame;
      for (int k = 0; k < CON; k++) begin
         check1($sformatf("%s_ctrl%0d", tag, k), control, f[CON-1]);
         check1($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
         f = f << 1;
         tick();
      end
   endtask

   task automatic do_write(input logic [IDW-1:0] id, input logic [DW-1:0] word,
                           input logic [CON-1:0] frame);
      logic [DW-1:0] w;
      w          = word;
      reqSlaveId = id;
      reqRW      = 1'b1;
      reqWrData  = word;
      ready      = 1'b1;
      reqStart   = 1'b1;
      tick();
      reqStart = 1'b0;
      ctrl_frame("wr", frame);
      check1("wr_wait_ctrl", control, 1'b0);
      check1("wr_wait_valid", valid, 1'b0);
      tick();
      for (int k = 0; k < DW; k++) begin
         check1($sformatf("wr_valid%0d", k), valid, 1'b1);
         check1($sformatf("wr_wd%0d", k), wD, w[DW-1]);
         check1($sformatf("wr_nodone%0d", k), done, 1'b0);
         w = w << 1;
         tick();
      end
      check1("wr_fin_done", done, 1'b1);
      check1("wr_fin_error", error, 1'b0);
      check1("wr_fin_valid", valid, 1'b0);
      check1("wr_fin_busy", busy, 1'b1);
      checkw("wr_rddata_held", rdData, exp_rd);
      tick();
      check1("wr_idle_busy", busy, 1'b0);
      check1("wr_idle_done", done, 1'b0);
   endtask

   task automatic do_read(input logic [IDW-1:0] id, input logic [DW-1:0] word,
                          input logic [CON-1:0] frame, input int pre_wait, input bit toggle);
      logic [DW-1:0] w;
      w          = word;
      reqSlaveId = id;
      reqRW      = 1'b0;
      ready      = 1'b0;
      rD         = 1'b0;
      reqStart   = 1'b1;
      tick();
      reqStart = 1'b0;
      ctrl_frame("rd", frame);
      for (int i = 0; i < pre_wait; i++) begin
         check1($sformatf("rd_wait_ctrl%0d", i), control, 1'b0);
         check1($sformatf("rd_wait_done%0d", i), done, 1'b0);
         tick();
      end
      for (int i = 0; i < DW; i++) begin
         ready = 1'b1;
         rD    = w[DW-1];
         check1($sformatf("rd_novalid%0d", i), valid, 1'b0);
         check1($sformatf("rd_noabort%0d", i), control, 1'b0);
         tick();
         if (toggle && (i < DW - 1)) begin
            ready = 1'b0;
            rD    = ~w[DW-1];
            check1($sformatf("rd_gap_valid%0d", i), valid, 1'b0);
            tick();
         end
         w = w << 1;
      end
      ready = 1'b0;
      rD    = 1'b0;
      check1("rd_ack_valid", valid, 1'b1);
      check1("rd_ack_done", done, 1'b0);
      tick();
      check1("rd_fin_done", done, 1'b1);
      check1("rd_fin_error", error, 1'b0);
      check1("rd_fin_valid", valid, 1'b0);
      checkw("rd_fin_rddata", rdData, word);
      exp_rd = word;
      tick();
      check1("rd_idle_busy", busy, 1'b0);
   endtask

   initial begin
      rstN       = 1'b0;
      reqStart   = 1'b0;
      reqSlaveId = '0;
      reqRW      = 1'b0;
      reqWrData  = '0;
      rD         = 1'b0;
      ready      = 1'b0;
      exp_rd     = '0;
      repeat (3) tick();
      checkw("rst_outputs", {26'd0, control, wD, valid, done, error, busy}, '0);
      checkw("rst_rddata", rdData, '0);
      rstN = 1'b1;
      tick();

      // Write id=1: frame 111 01 1
      do_write(2'd1, 32'hA5A5_0F0F, 6'b111011);

      // Read id=2 with ready alternating: frame 111 10 0
      do_read(2'd2, 32'hDEAD_BEEF, 6'b111100, 0, 1'b1);

      // Timeout on read id=3 with ready held low: frame 111 11 0
      reqSlaveId = 2'd3;
      reqRW      = 1'b0;
      ready      = 1'b0;
      reqStart   = 1'b1;
      tick();
      reqStart = 1'b0;
      ctrl_frame("to", 6'b111110);
      for (int i = 0; i < TO - 1; i++) begin
         check1($sformatf("to_wait_ctrl%0d", i), control, 1'b0);
         check1($sformatf("to_wait_done%0d", i), done, 1'b0);
         tick();
      end
      check1("to_abort0", control, 1'b1);
      tick();
      check1("to_abort1", control, 1'b0);
      check1("to_abort1_done", done, 1'b0);
      tick();
      check1("to_abort2", control, 1'b0);
      tick();
      check1("to_fin_done", done, 1'b1);
      check1("to_fin_error", error, 1'b1);
      checkw("to_rddata_held", rdData, 32'hDEAD_BEEF);
      tick();
      check1("to_idle_busy", busy, 1'b0);
      check1("to_idle_error", error, 1'b0);

      // ready rises on the expiry cycle of the first wait: frame 111 01 0
      do_read(2'd1, 32'h1234_5678, 6'b111010, TO - 2, 1'b0);

      // reqStart held high across a whole write
      reqSlaveId = 2'd2;
      reqRW      = 1'b1;
      reqWrData  = 32'h0F0F_1234;
      ready      = 1'b1;
      reqStart   = 1'b1;
      tick();
      dones = '0;
      for (int i = 0; i < CON + 1 + DW; i++) begin
         if (done || !busy) dones = dones + 1;
         tick();
      end
      checkw("held_no_early_done", dones, '0);
      check1("held_fin_done", done, 1'b1);
      check1("held_fin_busy", busy, 1'b1);
      tick();
      check1("held_busy_fell", busy, 1'b0);
      tick();
      check1("held_second_busy", busy, 1'b1);
      check1("held_second_ctrl", control, 1'b1);
      reqStart = 1'b0;

      // Reset mid-WRITE of the second transaction (cycle k=5, wD = bit 26 of 0F0F1234)
      repeat (CON + 1 + 5) tick();
      check1("mid_valid", valid, 1'b1);
      check1("mid_wd", wD, 1'b1);
      #2;
      rstN = 1'b0;
      #1;
      checkw("async_rst_outputs", {26'd0, control, wD, valid, done, error, busy}, '0);
      checkw("async_rst_rddata", rdData, '0);
      tick();
      rstN   = 1'b1;
      exp_rd = '0;
      tick();
      check1("post_rst_busy", busy, 1'b0);

      // Normal write after reset, id=3: frame 111 11 1
      do_write(2'd3, 32'h8000_0001, 6'b111111);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
